case_1_mul_share_arb: RTL and testbench

- Round-robin arbiter and sequencer that time-shares one signed multiplier (6-bit signed by 3-bit signed, 6-bit result) among NUM_REQ requesters.
- Each requester presents an operand pair with a valid/ready handshake.
- The block grants one requester, registers its operands, computes the product, and returns it on a single response channel tagged with the requester index.
- Sits between the HLS dataflow loops of case_1 and their shared multiply resource.

---
 rtl/case_1_mul_share_arb.sv | 132 +++++++++++++
 tb/tb_case_1_mul_share_arb.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/case_1_mul_share_arb.sv
// case_1_mul_share_arb
// Round-robin arbiter and sequencer that time-shares one signed multiplier
// (A_WIDTH x B_WIDTH, low DOUT_WIDTH bits kept) among NUM_REQ requesters.
//
// Ports:
//   ap_clk     - clock, rising edge
//   ap_rst     - synchronous active-high reset
//   req_valid  - per-requester request valid
//   req_ready  - per-requester accept, one-hot or zero (combinational in S_IDLE)
//   req_a      - packed operand A, requester i at [i*A_WIDTH +: A_WIDTH]
//   req_b      - packed operand B, requester i at [i*B_WIDTH +: B_WIDTH]
//   rsp_valid  - response valid
//   rsp_ready  - response consumer ready
//   rsp_data   - low DOUT_WIDTH bits of the signed product
//   rsp_id     - requester index of the response
//   busy       - high whenever the FSM is not idle
//   op_count   - completed responses, wrapping
module case_1_mul_share_arb #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ID_WIDTH   = 2,
    parameter int unsigned A_WIDTH    = 6,
    parameter int unsigned B_WIDTH    = 3,
    parameter int unsigned DOUT_WIDTH = 6,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*A_WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*B_WIDTH-1:0]   req_b,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [DOUT_WIDTH-1:0]        rsp_data,
    output logic [ID_WIDTH-1:0]          rsp_id,
    output logic                         busy,
    output logic [CNT_WIDTH-1:0]         op_count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_RSP  = 2'd2;

    logic [1:0]                        state_q, state_d;
    logic [ID_WIDTH-1:0]               ptr_q;
    logic signed [A_WIDTH-1:0]         a_q;
    logic signed [B_WIDTH-1:0]         b_q;
    logic [ID_WIDTH-1:0]               id_q;
    logic                              busy_q;
    logic [DOUT_WIDTH-1:0]             rsp_data_q;
    logic [ID_WIDTH-1:0]               rsp_id_q;
    logic [CNT_WIDTH-1:0]              op_count_q;

    logic [NUM_REQ-1:0]                grant;
    logic [ID_WIDTH-1:0]               grant_id;
    logic                              grant_found;
    logic                              handshake;
    logic                              rsp_fire;
    logic signed [A_WIDTH+B_WIDTH-1:0] prod_full;

    // First valid requester at or above the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        grant       = '0;
        grant_id    = '0;
        grant_found = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            int unsigned cand;
            cand = (int'(ptr_q) + k) % NUM_REQ;
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant[cand] = 1'b1;
                grant_id    = ID_WIDTH'(cand);
            end
        end
    end

    // req_ready depends only on state and req_valid, never on rsp_ready.
    assign req_ready = (state_q == S_IDLE) ? grant : '0;
    assign handshake = (state_q == S_IDLE) && grant_found;
    assign rsp_fire  = (state_q == S_RSP) && rsp_ready;

    // Both operands signed, so the product is sign-extended to the full width.
    assign prod_full = a_q * b_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (handshake) state_d = S_MUL;
            S_MUL:   state_d = S_RSP;
            S_RSP:   if (rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            id_q       <= '0;
            busy_q     <= 1'b0;
            rsp_data_q <= '0;
            rsp_id_q   <= '0;
            op_count_q <= '0;
        end else begin
            state_q <= state_d;
            // Registered alongside the state so it is high exactly when not idle.
            busy_q  <= (state_d != S_IDLE);
            if (handshake) begin
                a_q   <= req_a[grant_id*A_WIDTH +: A_WIDTH];
                b_q   <= req_b[grant_id*B_WIDTH +: B_WIDTH];
                id_q  <= grant_id;
                ptr_q <= ID_WIDTH'((int'(grant_id) + 1) % NUM_REQ);
            end
            if (state_q == S_MUL) begin
                rsp_data_q <= prod_full[DOUT_WIDTH-1:0];
                rsp_id_q   <= id_q;
            end
            if (rsp_fire) begin
                op_count_q <= op_count_q + CNT_WIDTH'(1);
            end
        end
    end

    assign rsp_valid = (state_q == S_RSP);
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = busy_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_case_1_mul_share_arb.sv
// tb_case_1_mul_share_arb
// Directed-vector bench for case_1_mul_share_arb with hand-computed expectations.
module tb_case_1_mul_share_arb;

    localparam int NR = 4;
    localparam int AW = 6;
    localparam int BW = 3;

    logic          ap_clk;
    logic          ap_rst;
    logic [NR-1:0] req_valid;
    logic [NR-1:0] req_ready;
    logic [NR*AW-1:0] req_a;
    logic [NR*BW-1:0] req_b;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [5:0]    rsp_data;
    logic [1:0]    rsp_id;
    logic          busy;
    logic [15:0]   op_count;

    int n_checks;
    int n_fail;
    int exp_count;

    case_1_mul_share_arb dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .busy      (busy),
        .op_count  (op_count)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge ap_clk);
        #2;
    endtask

    task automatic run_single(input int id, input int a, input int b, input logic [5:0] exp_data);
        req_a = '0;
        req_b = '0;
        req_a[id*AW +: AW] = AW'(a);
        req_b[id*BW +: BW] = BW'(b);
        req_valid = NR'(1 << id);
        rsp_ready = 1'b1;
        #1;
        check_eq("accept_ready", 32'(req_ready), 32'(1 << id));
        step();
        req_valid = '0;
        #1;
        check_eq("mul_ready_zero", 32'(req_ready), 32'd0);
        check_eq("mul_busy", 32'(busy), 32'd1);
        check_eq("mul_no_rsp", 32'(rsp_valid), 32'd0);
        step();
        check_eq("rsp_valid", 32'(rsp_valid), 32'd1);
        check_eq("rsp_data", 32'(rsp_data), 32'(exp_data));
        check_eq("rsp_id", 32'(rsp_id), 32'(id));
        step();
        exp_count++;
        check_eq("op_count", 32'(op_count), 32'(exp_count));
        check_eq("rsp_valid_drop", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        int nrsp;
        int last_cyc;
        n_checks  = 0;
        n_fail    = 0;
        exp_count = 0;
        ap_rst    = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        step();
        step();
        ap_rst = 1'b0;

        // Idle after reset: every output zero.
        for (int i = 0; i < 10; i++) begin
            step();
            check_eq("idle_outputs",
                     {8'd0, req_ready, rsp_valid, rsp_data, rsp_id, busy, op_count},
                     32'd0);
        end

        // Single request and signed-wrap products.
        run_single(2, 5, 3, 6'h0F);
        run_single(0, -32, 3, 6'b100000);
        run_single(1, -3, -2, 6'b000110);
        run_single(3, 31, -4, 6'b000100);

        // Pointer is now 0: all requesters valid, expect 0,1,2,3,0,1,2,3 every 3 cycles.
        for (int i = 0; i < NR; i++) begin
            req_a[i*AW +: AW] = AW'(i + 1);
            req_b[i*BW +: BW] = BW'(2);
        end
        req_valid = '1;
        rsp_ready = 1'b1;
        nrsp      = 0;
        last_cyc  = 0;
        for (int cyc = 0; cyc < 40 && nrsp < 8; cyc++) begin
            if (rsp_valid) begin
                check_eq("rr_id", 32'(rsp_id), 32'(nrsp % NR));
                check_eq("rr_data", 32'(rsp_data), 32'(((nrsp % NR) + 1) * 2));
                if (nrsp > 0) check_eq("rr_spacing", 32'(cyc - last_cyc), 32'd3);
                last_cyc = cyc;
                nrsp++;
                if (nrsp == 8) req_valid = '0;
            end
            step();
        end
        check_eq("rr_count", 32'(nrsp), 32'd8);
        exp_count += 8;
        check_eq("rr_op_count", 32'(op_count), 32'(exp_count));

        // Backpressure: 7 * -1 = -7 -> 6'h39, held for 5 cycles.
        req_a = '0;
        req_b = '0;
        req_a[1*AW +: AW] = AW'(7);
        req_b[1*BW +: BW] = BW'(-1);
        req_valid = 4'b0010;
        rsp_ready = 1'b0;
        #1;
        check_eq("bp_accept", 32'(req_ready), 32'b0010);
        step();
        req_valid = '0;
        step();
        req_valid = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_eq("bp_valid", 32'(rsp_valid), 32'd1);
            check_eq("bp_data", 32'(rsp_data), 32'h39);
            check_eq("bp_id", 32'(rsp_id), 32'd1);
            check_eq("bp_ready_zero", 32'(req_ready), 32'd0);
            check_eq("bp_count", 32'(op_count), 32'(exp_count));
            step();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        step();
        exp_count++;
        check_eq("bp_done_count", 32'(op_count), 32'(exp_count));
        check_eq("bp_done_valid", 32'(rsp_valid), 32'd0);
        step();
        step();
        check_eq("bp_one_only_valid", 32'(rsp_valid), 32'd0);
        check_eq("bp_one_only_count", 32'(op_count), 32'(exp_count));

        // Reset while in S_MUL with requester 1 pending.
        req_a = '0;
        req_b = '0;
        req_a[0 +: AW] = AW'(1);
        req_b[0 +: BW] = BW'(1);
        req_a[1*AW +: AW] = AW'(2);
        req_b[1*BW +: BW] = BW'(1);
        req_valid = 4'b0001;
        #1;
        check_eq("rst_pre_accept", 32'(req_ready), 32'b0001);
        step();
        req_valid = 4'b0010;
        ap_rst    = 1'b1;
        step();
        ap_rst    = 1'b0;
        req_valid = '0;
        exp_count = 0;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_rsp_data", 32'(rsp_data), 32'd0);
        check_eq("rst_rsp_id", 32'(rsp_id), 32'd0);
        check_eq("rst_op_count", 32'(op_count), 32'd0);
        step();
        check_eq("rst_no_rsp", 32'(rsp_valid), 32'd0);
        check_eq("rst_idle_busy", 32'(busy), 32'd0);
        req_valid = 4'b0011;
        #1;
        check_eq("rst_ptr_zero", 32'(req_ready), 32'b0001);
        step();
        req_valid = '0;
        step();
        check_eq("rst_after_valid", 32'(rsp_valid), 32'd1);
        check_eq("rst_after_id", 32'(rsp_id), 32'd0);
        check_eq("rst_after_data", 32'(rsp_data), 32'd1);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
